// File: rtl/seq_divmod_pkg.sv
// seq_divmod_pkg: shared FSM encoding and counter sizing for the sequential divider.
package seq_divmod_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/divmod_step.sv
// divmod_step: one combinational restoring-division iteration (shift in a dividend bit, trial subtract).
module divmod_step
    import seq_divmod_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] p,
    input  logic                 msb,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic [DATAWIDTH-1:0] p_next,
    output logic                 qbit
);

    logic [DATAWIDTH:0] ps, t;

    assign ps     = {p, msb};
    assign t      = ps - {1'b0, divisor};
    assign qbit   = ~t[DATAWIDTH];
    assign p_next = qbit ? t[DATAWIDTH-1:0] : ps[DATAWIDTH-1:0];

endmodule

// File: rtl/seq_divmod.sv
// seq_divmod: multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVMOD_SIGNED_EN for two's-complement operands with truncating division.
module seq_divmod
    import seq_divmod_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int CW = cnt_width(DATAWIDTH);

    state_t               state, state_n;
    logic [DATAWIDTH-1:0] dvd, dvs, p, a_lat, p_next, ua, ub, qraw, qfin, rfin;
    logic [CW-1:0]        cnt;
    logic                 qbit, dz, last;

    assign qraw = {dvd[DATAWIDTH-2:0], qbit};

`ifdef SEQ_DIVMOD_SIGNED_EN
    logic neg_q, neg_r;
    assign ua   = a[DATAWIDTH-1] ? -a : a;
    assign ub   = b[DATAWIDTH-1] ? -b : b;
    assign qfin = dz ? (a_lat[DATAWIDTH-1] ? DATAWIDTH'(1) : '1) : neg_q ? -qraw : qraw;
    assign rfin = dz ? a_lat : neg_r ? -p_next : p_next;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
            neg_r <= a[DATAWIDTH-1];
        end
    end
`else
    assign ua   = a;
    assign ub   = b;
    assign qfin = dz ? '1 : qraw;
    assign rfin = dz ? a_lat : p_next;
`endif

    assign last = cnt == CW'(1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    divmod_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .p      (p),
        .msb    (dvd[DATAWIDTH-1]),
        .divisor(dvs),
        .p_next (p_next),
        .qbit   (qbit)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? (start ? RUN : IDLE) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    // A zero divisor spends a single RUN cycle so its result lands one edge after the start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dvd         <= '0;
            dvs         <= '0;
            p           <= '0;
            a_lat       <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            dvd   <= ua;
            dvs   <= ub;
            p     <= '0;
            a_lat <= a;
            dz    <= b == '0;
            cnt   <= (b == '0) ? CW'(1) : CW'(DATAWIDTH);
        end else if (state == RUN) begin
            dvd <= qraw;
            p   <= p_next;
            cnt <= cnt - CW'(1);
            if (last) begin
                quot        <= qfin;
                rem         <= rfin;
                div_by_zero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_seq_divmod.sv
// tb_seq_divmod: randomized scoreboard bench for seq_divmod against an arithmetic reference model.
module tb_seq_divmod;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quot, rem;

    always #5 Clk = ~Clk;

    seq_divmod #(.DATAWIDTH(DW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        int            done_at;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   free_at = 0;
    int   busy_from = 1;
    int   busy_to = 0;
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input int at);
        exp_t e;
`ifdef SEQ_DIVMOD_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
`endif
        e.r       = x;
        e.dz      = (y == '0);
        e.done_at = at + ((y == '0) ? 1 : DW);
`ifdef SEQ_DIVMOD_SIGNED_EN
        if (y == '0) e.q = (sx >= 0) ? '1 : DW'(1);
        else begin
            e.q = DW'(sx / sy);
            e.r = DW'(sx % sy);
        end
`else
        if (y == '0) e.q = '1;
        else begin
            e.q = x / y;
            e.r = x % y;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Stimulus-side model: decides which starts the divider accepts and when each result is due.
    initial forever begin
        @(posedge Clk);
        edge_n++;
        if (Rst) begin
            free_at   = 0;
            busy_from = 1;
            busy_to   = 0;
        end else if (start && edge_n >= free_at) begin
            sb.push_back(model(a, b, edge_n));
            busy_from = edge_n;
            busy_to   = sb[$].done_at;
            free_at   = busy_to + 2;
        end
    end

    // Monitor: compares handshake and held results once per cycle, away from the clock edge.
    initial begin : mon
        exp_t          e;
        logic [DW-1:0] hold_q, hold_r;
        logic          hold_dz;
        hold_q  = '0;
        hold_r  = '0;
        hold_dz = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (Rst) begin
                sb.delete();
                hold_q  = '0;
                hold_r  = '0;
                hold_dz = 1'b0;
            end
            chk("busy", busy, (edge_n >= busy_from && edge_n <= busy_to));
            if (sb.size() > 0 && edge_n == sb[0].done_at) begin
                e       = sb.pop_front();
                hold_q  = e.q;
                hold_r  = e.r;
                hold_dz = e.dz;
                chk("done_on_time", done, 1);
            end else chk("no_done", done, 0);
            chk("quot", quot, hold_q);
            chk("rem", rem, hold_r);
            chk("div_by_zero", div_by_zero, hold_dz);
        end
    end

    task automatic pulse(input logic [DW-1:0] x, input logic [DW-1:0] y);
        @(negedge Clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (DW + 4) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        pulse(8'd100, 8'd7);
        idle_wait();
        @(negedge Clk);
        a     = 8'd255;
        b     = 8'd1;
        start = 1'b1;
        @(negedge Clk);
        a = 8'd3;
        b = 8'd200;
        repeat (10) @(negedge Clk);
        start = 1'b0;
        idle_wait();
        pulse(8'd5, 8'd0);
        repeat (4) @(negedge Clk);
        pulse(8'd20, 8'd3);
        idle_wait();
        pulse(8'd100, 8'd7);
        repeat (2) @(negedge Clk);
        pulse(8'd9, 8'd9);
        idle_wait();
        pulse(8'd50, 8'd3);
        repeat (3) @(negedge Clk);
        do_reset();
        pulse(8'd20, 8'd6);
        idle_wait();
`ifdef SEQ_DIVMOD_SIGNED_EN
        pulse(DW'(-7), 8'd2);
        idle_wait();
        pulse(8'd7, DW'(-2));
        idle_wait();
        pulse(8'h80, 8'hFF);
        idle_wait();
        pulse(DW'(-9), 8'd0);
        idle_wait();
`endif
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            a     = DW'($urandom);
            b     = ($urandom_range(0, 6) == 0) ? '0 : DW'($urandom);
            start = 1'b1;
            repeat ($urandom_range(1, DW + 4)) @(negedge Clk);
            start = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end
        idle_wait();
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
